dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path (requester 0) and the program/debug loader (requester 1). It accepts at most one access per cycle through a valid/ready handshake and registers the winning access onto the memory port. It returns read data with fixed latency and supports bounded locked sequences for atomic read-modify-write.

## Interface
- ADDR_W, default 8: word-address width (256-word data memory)
- DATA_W, default 32: data width
- MAX_LOCK, default 4: maximum consecutive locked beats before forced release (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rN_req  in  1  requester N (N=0,1) access valid
- rN_we  in  1  1 = write, 0 = read
- rN_lock  in  1  keep grant after this beat
- rN_addr  in  ADDR_W  word address
- rN_wdata  in  DATA_W  write data
- rN_gnt  out  1  combinational ready; a beat is accepted on an edge where rN_req & rN_gnt
- rN_rvalid  out  1  read data valid for requester N, one-cycle pulse per read
- rN_rdata  out  DATA_W  equals mem_rdata; meaningful only when rN_rvalid
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after mem_en & !mem_we

## Operation
- States: IDLE, LOCK0, LOCK1. State resets to IDLE.
- IDLE: if exactly one req is high, that requester gets gnt. If both are high, the winner is chosen by policy (see Configuration).
- LOCKn: only rN_gnt can be high (= rN_req); the other requester's gnt is 0.
- Accepted beat from N with rN_lock=1: next state is LOCKn and lock_cnt increments. With rN_lock=0: next state is IDLE and lock_cnt clears.
- lock_cnt reaching MAX_LOCK on an accepted locked beat forces IDLE and sets the round-robin pointer to favour the other requester. rN_lock on that beat is ignored.
- In LOCKn with rN_req=0, the state holds. No timeout exists while idle-locked; release comes only from an accepted beat.
- On each accepted beat, mem_en=1 and mem_we/addr/wdata are registered from the winner. With no accept, mem_en=0, mem_we=0, and addr/wdata hold.
- Reads: a 2-stage tag pipe (valid + requester id) tracks each read. rN_rvalid is asserted for the owning requester only.
- Writes produce no response.
- No backpressure from memory. Throughput is one beat per cycle.

## Timing
- Reset (reset_n=0, asynchronous): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, r0_rvalid=r1_rvalid=0, lock_cnt=0, RR pointer favours r0, state=IDLE. rN_gnt=0 while reset_n=0.
- Accept at edge E0 → mem_en high in cycle E0..E1 → mem_rdata valid and rN_rvalid high in cycle E1..E2. Read latency is 2 cycles from the accept edge.
- Back-to-back reads from alternating requesters produce consecutive rvalid pulses, each correctly steered.
- Reset asserted mid-operation flushes the tag pipe. No rvalid appears after reset_n rises for reads accepted before reset.
- gnt depends only on req, state, and the pointer; it has no dependence on wdata/addr. No combinational path from mem_rdata to gnt.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie in IDLE, the requester not granted most recently wins. The pointer updates on every accepted beat.
- DMEM_ARB_RR_EN undefined: fixed priority. r0 (CPU) always wins ties. The pointer logic is removed, except that forced lock release still grants the other requester on the next tie (one-shot override).

## Test plan
- Reset: hold reset_n=0 with r0_req=r1_req=1 → both gnt=0, mem_en=0. Release reset → r0 granted first.
- Single read: r1 read addr 0x10, memory word 0xDEADBEEF → mem_en/mem_addr=0x10 one cycle after accept, r1_rvalid with r1_rdata=0xDEADBEEF 2 cycles after accept, r0_rvalid stays 0.
- Tie, continuous: both req=1 for 6 cycles → with DMEM_ARB_RR_EN, grants alternate 0,1,0,1,0,1. Without it, r0 gets all 6.
- Lock: r1 write with lock=1, then r0_req=1 → r0_gnt=0 until r1's next beat with lock=0, after which r0 is granted.
- Lock timeout with MAX_LOCK=4: r1 issues 5 locked beats while r0 requests → r0 is granted on the cycle after r1's 4th beat.
- Mid-flight reset: r0 read accepted, reset_n pulsed low the next cycle → no r0_rvalid after reset; all outputs at reset values.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with bounded locking.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise r0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_ptr;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_t1_v;
    logic               r_t1_id;
    logic               r_t2_v;
    logic               r_t2_id;

    logic               w_tie;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_acc;
    logic               w_id;
    logic               w_we;
    logic               w_lock;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_force;

    assign w_tie = (r_state == IDLE) && r0_req && r1_req;

    // r_ptr=1 means r1 wins the next tie
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset_n) begin
            unique case (r_state)
                IDLE: begin
                    if (w_tie) begin
                        w_gnt0 = ~r_ptr;
                        w_gnt1 = r_ptr;
                    end else begin
                        w_gnt0 = r0_req;
                        w_gnt1 = r1_req;
                    end
                end
                LOCK0:   w_gnt0 = r0_req;
                LOCK1:   w_gnt1 = r1_req;
                default: ;
            endcase
        end
    end

    assign w_acc     = (r0_req && w_gnt0) || (r1_req && w_gnt1);
    assign w_id      = r1_req && w_gnt1;
    assign w_we      = w_id ? r1_we    : r0_we;
    assign w_lock    = w_id ? r1_lock  : r0_lock;
    assign w_addr    = w_id ? r1_addr  : r0_addr;
    assign w_wdata   = w_id ? r1_wdata : r0_wdata;
    assign w_cnt_nxt = r_lock_cnt + CNT_W'(1);
    assign w_force   = w_lock && (w_cnt_nxt == CNT_W'(MAX_LOCK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_lock_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_t1_v      <= 1'b0;
            r_t1_id     <= 1'b0;
            r_t2_v      <= 1'b0;
            r_t2_id     <= 1'b0;
        end else begin
            r_mem_en <= w_acc;
            r_mem_we <= w_acc && w_we;
            r_t1_v   <= w_acc && !w_we;
            r_t1_id  <= w_id;
            r_t2_v   <= r_t1_v;
            r_t2_id  <= r_t1_id;
            if (w_acc) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                if (w_force) begin
                    r_state    <= IDLE;
                    r_lock_cnt <= '0;
                end else if (w_lock) begin
                    r_state    <= w_id ? LOCK1 : LOCK0;
                    r_lock_cnt <= w_cnt_nxt;
                end else begin
                    r_state    <= IDLE;
                    r_lock_cnt <= '0;
                end
`ifdef DMEM_ARB_RR_EN
                r_ptr <= ~w_id;
`else
                // one-shot override after a forced lock release
                if (w_force)
                    r_ptr <= ~w_id;
                else if (w_tie)
                    r_ptr <= 1'b0;
`endif
            end
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = r_t2_v && !r_t2_id;
    assign r1_rvalid = r_t2_v && r_t2_id;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
